flag_unit: RTL and testbench
============================

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-high, and the clock and reset ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 res_valid  input  1  ALU result present this cycle.
REQ-005 exec  input  1  condition-pass for current instruction; 0 squashes the flag update.
REQ-006 stall  input  1  pipeline hold; 1 blocks ALU/MUL flag updates.
REQ-007 alu_op  input  4  ARM data-processing opcode: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, 6 SBC, 7 RSC, 8 TST, 9 TEQ, 10 CMP, 11 CMN, 12 ORR, 13 MOV, 14 BIC, 15 MVN.
REQ-008 s_bit  input  1  set-flags bit.
REQ-009 is_mul  input  1  result comes from the multiplier, not the ALU.
REQ-010 alu_result  input  32  result value.
REQ-011 alu_cout  input  1  adder carry-out, with ARM borrow convention: C=1 means no borrow.
REQ-012 shifter_cout  input  1  barrel-shifter carry-out.
REQ-013 op_a_msb, op_b_msb  input  1 each  bit 31 of first operand (Rn) and second operand (shifter output).
REQ-014 msr_we  input  1  direct flag write.
REQ-015 msr_data  input  4  value for msr_we.
REQ-016 save  input  1  exception entry: copy flags into the saved-flags register.
REQ-017 restore  input  1  exception return: copy saved flags into the live flags.
REQ-018 nzcv  output  4  registered live flags: [3] N, [2] Z, [1] C, [0] V.
REQ-019 spsr_f  output  4  registered saved flags, same bit order as nzcv.
REQ-020 carry_in  output  1  combinational, equal to nzcv[1]; feeds ADC/SBC/RSC.
REQ-021 flag_upd  output  1  registered pulse, 1 in the cycle after nzcv was written.

Function
REQ-022 An ALU update SHALL occur when res_valid=1, exec=1, stall=0, is_mul=0, and either s_bit=1 or alu_op is in 8..11 (test/compare opcodes update flags regardless of s_bit).
REQ-023 On an ALU update, nzcv SHALL load on the next rising edge as follows:
- N = alu_result[31].
- Z = (alu_result == 0).
REQ-024 For arithmetic opcodes (2-7, 10, 11), C SHALL equal alu_cout and V SHALL be computed as:
- ADD/ADC/CMN: V = (a==b) & (r!=a).
- SUB/SBC/CMP: V = (a!=b) & (r!=a).
- RSB/RSC: V = (a!=b) & (r!=b).
- a = op_a_msb, b = op_b_msb, r = alu_result[31].
REQ-025 For logical opcodes (0, 1, 8, 9, 12-15), C SHALL equal shifter_cout and V SHALL hold its previous value.
REQ-026 A MUL update SHALL occur when res_valid=1, exec=1, stall=0, is_mul=1 and s_bit=1; it SHALL update N and Z only, and C and V SHALL hold.
REQ-027 Write priority on nzcv, highest first:
- restore: nzcv <= spsr_f.
- msr_we: nzcv <= msr_data.
- ALU or MUL update.
- otherwise hold.
REQ-028 msr_we, save and restore SHALL ignore exec and stall.
REQ-029 save SHALL load spsr_f with the pre-edge nzcv value, independent of any same-cycle nzcv write.
REQ-030 When save and restore are both 1, the two registers SHALL swap: nzcv <= old spsr_f and spsr_f <= old nzcv.
REQ-031 Update latency SHALL be one cycle: flags are visible on nzcv the cycle after the qualifying inputs.
REQ-032 flag_upd SHALL be 1 for exactly the one cycle following any nzcv write (restore, msr_we, ALU or MUL), even if the written value equals the old one.
REQ-033 carry_in SHALL reflect the registered C flag and SHALL NOT bypass a same-cycle update.
REQ-034 With res_valid=0, no flag state SHALL change except through msr_we, save or restore.

Reset
REQ-035 While rst=1, nzcv, spsr_f and flag_upd SHALL be 0 immediately, without waiting for a clock edge.
REQ-036 Reset asserted mid-operation SHALL discard any pending update, and the first edge after rst falls SHALL behave as a normal cycle.

Verification
REQ-037 ADD with s_bit=1, a=0, b=0, result 0x8000_0000, alu_cout=0 -> nzcv=4'b1001 next cycle; flag_upd=1 for one cycle.
REQ-038 CMP with s_bit=0, result 0, alu_cout=1, a=b=0 -> nzcv=4'b0110; the same inputs with exec=0 -> nzcv unchanged and flag_upd=0.
REQ-039 Starting at nzcv=4'b0001, MOVS with result 0, shifter_cout=1 -> nzcv=4'b0111 (V held); the same instruction with stall=1 -> no change.
REQ-040 MULS with result 0xFFFF_FFFF starting at nzcv=4'b0011 -> nzcv=4'b1011.
REQ-041 Starting at nzcv=4'b1010, spsr_f=4'b0101, assert save and restore together -> nzcv=4'b0101, spsr_f=4'b1010; restore together with msr_we=1, msr_data=4'b1111 -> nzcv=spsr_f.
REQ-042 Assert rst asynchronously between clock edges with nzcv=4'b1111 -> nzcv=0, spsr_f=0 and flag_upd=0 before the next edge.

Source files
------------

// File: rtl/flag_unit.sv
// Condition flag unit: live NZCV, saved flags and update pulse.
// Handles ALU/MUL flag setting, direct writes and exception save/restore.
module flag_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    input  logic        exec,
    input  logic        stall,
    input  logic [3:0]  alu_op,
    input  logic        s_bit,
    input  logic        is_mul,
    input  logic [31:0] alu_result,
    input  logic        alu_cout,
    input  logic        shifter_cout,
    input  logic        op_a_msb,
    input  logic        op_b_msb,
    input  logic        msr_we,
    input  logic [3:0]  msr_data,
    input  logic        save,
    input  logic        restore,
    output logic [3:0]  nzcv,
    output logic [3:0]  spsr_f,
    output logic        carry_in,
    output logic        flag_upd
);

    logic       is_add;
    logic       is_sub;
    logic       is_rsb;
    logic       is_tst;
    logic       arith;
    logic       qual;
    logic       alu_upd;
    logic       mul_upd;
    logic       r_msb;
    logic       r_zero;
    logic       v_arith;
    logic       wr;
    logic [3:0] nzcv_nxt;

    always_comb begin
        is_add = 1'b0;
        is_sub = 1'b0;
        is_rsb = 1'b0;
        case (alu_op)
            4'd4, 4'd5, 4'd11: is_add = 1'b1;
            4'd2, 4'd6, 4'd10: is_sub = 1'b1;
            4'd3, 4'd7:        is_rsb = 1'b1;
            default:           ;
        endcase
    end

    // Opcodes 8..11 (TST/TEQ/CMP/CMN) always set flags.
    assign is_tst  = (alu_op[3:2] == 2'b10);
    assign arith   = is_add | is_sub | is_rsb;
    assign qual    = res_valid & exec & ~stall;
    assign alu_upd = qual & ~is_mul & (s_bit | is_tst);
    assign mul_upd = qual & is_mul & s_bit;
    assign r_msb   = alu_result[31];
    assign r_zero  = (alu_result == 32'd0);

    always_comb begin
        v_arith = 1'b0;
        unique case (1'b1)
            is_add:  v_arith = (op_a_msb == op_b_msb) & (r_msb != op_a_msb);
            is_sub:  v_arith = (op_a_msb != op_b_msb) & (r_msb != op_a_msb);
            is_rsb:  v_arith = (op_a_msb != op_b_msb) & (r_msb != op_b_msb);
            default: v_arith = 1'b0;
        endcase
    end

    always_comb begin
        nzcv_nxt = nzcv;
        wr       = 1'b0;
        if (restore) begin
            nzcv_nxt = spsr_f;
            wr       = 1'b1;
        end else if (msr_we) begin
            nzcv_nxt = msr_data;
            wr       = 1'b1;
        end else if (alu_upd) begin
            nzcv_nxt[3] = r_msb;
            nzcv_nxt[2] = r_zero;
            nzcv_nxt[1] = arith ? alu_cout : shifter_cout;
            nzcv_nxt[0] = arith ? v_arith : nzcv[0];
            wr          = 1'b1;
        end else if (mul_upd) begin
            nzcv_nxt[3] = r_msb;
            nzcv_nxt[2] = r_zero;
            wr          = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzcv     <= 4'd0;
            spsr_f   <= 4'd0;
            flag_upd <= 1'b0;
        end else begin
            nzcv     <= nzcv_nxt;
            flag_upd <= wr;
            if (save)
                spsr_f <= nzcv;
        end
    end

    assign carry_in = nzcv[1];

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed cases plus random
// stimulus against a behavioural flag model.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid = 1'b0;
    logic        exec = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  alu_op = 4'd0;
    logic        s_bit = 1'b0;
    logic        is_mul = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic        alu_cout = 1'b0;
    logic        shifter_cout = 1'b0;
    logic        op_a_msb = 1'b0;
    logic        op_b_msb = 1'b0;
    logic        msr_we = 1'b0;
    logic [3:0]  msr_data = 4'd0;
    logic        save = 1'b0;
    logic        restore = 1'b0;
    logic [3:0]  nzcv;
    logic [3:0]  spsr_f;
    logic        carry_in;
    logic        flag_upd;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0] m_nzcv = 4'd0;
    logic [3:0] m_spsr = 4'd0;
    logic       m_upd = 1'b0;

    flag_unit dut (
        .clk(clk), .rst(rst), .res_valid(res_valid), .exec(exec),
        .stall(stall), .alu_op(alu_op), .s_bit(s_bit), .is_mul(is_mul),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .shifter_cout(shifter_cout), .op_a_msb(op_a_msb),
        .op_b_msb(op_b_msb), .msr_we(msr_we), .msr_data(msr_data),
        .save(save), .restore(restore), .nzcv(nzcv), .spsr_f(spsr_f),
        .carry_in(carry_in), .flag_upd(flag_upd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: evaluates the architectural rules for one clock edge.
    task automatic model_edge();
        logic [3:0] nx;
        logic       w;
        logic       sets;
        int         kind;  // 0 logical, 1 add-like, 2 sub-like, 3 reverse-sub
        logic       rs;
        int o;
        o    = alu_op;
        nx   = m_nzcv;
        w    = 1'b0;
        sets = s_bit || (o >= 8 && o <= 11);
        if (o == 4 || o == 5 || o == 11) kind = 1;
        else if (o == 2 || o == 6 || o == 10) kind = 2;
        else if (o == 3 || o == 7) kind = 3;
        else kind = 0;
        rs = alu_result[31];
        if (restore) begin
            nx = m_spsr; w = 1'b1;
        end else if (msr_we) begin
            nx = msr_data; w = 1'b1;
        end else if (res_valid && exec && !stall && !is_mul && sets) begin
            nx[3] = rs;
            nx[2] = (alu_result == 0);
            if (kind == 0) begin
                nx[1] = shifter_cout;
            end else begin
                nx[1] = alu_cout;
                case (kind)
                    1: nx[0] = (op_a_msb == op_b_msb) && (rs != op_a_msb);
                    2: nx[0] = (op_a_msb != op_b_msb) && (rs != op_a_msb);
                    default: nx[0] = (op_a_msb != op_b_msb) && (rs != op_b_msb);
                endcase
            end
            w = 1'b1;
        end else if (res_valid && exec && !stall && is_mul && s_bit) begin
            nx[3] = rs;
            nx[2] = (alu_result == 0);
            w = 1'b1;
        end
        if (save) m_spsr = m_nzcv;
        m_nzcv = nx;
        m_upd  = w;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".nzcv"}, nzcv, m_nzcv);
        chk({tag, ".spsr"}, spsr_f, m_spsr);
        chk({tag, ".upd"}, {3'd0, flag_upd}, {3'd0, m_upd});
        chk({tag, ".cin"}, {3'd0, carry_in}, {3'd0, m_nzcv[1]});
    endtask

    task automatic idle();
        res_valid = 0; exec = 0; stall = 0; alu_op = 0; s_bit = 0;
        is_mul = 0; alu_result = 0; alu_cout = 0; shifter_cout = 0;
        op_a_msb = 0; op_b_msb = 0; msr_we = 0; msr_data = 0;
        save = 0; restore = 0;
    endtask

    task automatic alu(input logic [3:0] op, input logic s,
                       input logic [31:0] r, input logic c,
                       input logic sc, input logic a, input logic b);
        idle();
        res_valid = 1; exec = 1; alu_op = op; s_bit = s;
        alu_result = r; alu_cout = c; shifter_cout = sc;
        op_a_msb = a; op_b_msb = b;
    endtask

    task automatic msr(input logic [3:0] d);
        idle();
        msr_we = 1; msr_data = d;
    endtask

    initial begin
        idle();
        #2;
        chk("rst.nzcv", nzcv, 4'd0);
        chk("rst.spsr", spsr_f, 4'd0);
        chk("rst.upd", {3'd0, flag_upd}, 4'd0);
        @(negedge clk);
        rst = 0;

        alu(4'd4, 1, 32'h8000_0000, 0, 0, 0, 0);
        step("adds");
        chk("adds.const", nzcv, 4'b1001);
        chk("adds.pulse", {3'd0, flag_upd}, 4'd1);
        idle();
        step("adds.after");
        chk("adds.pulse_end", {3'd0, flag_upd}, 4'd0);

        alu(4'd10, 0, 32'd0, 1, 0, 0, 0);
        step("cmp");
        chk("cmp.const", nzcv, 4'b0110);
        alu(4'd10, 0, 32'h8000_0000, 0, 0, 0, 0);
        exec = 0;
        step("cmp.squash");
        chk("cmp.squash.const", nzcv, 4'b0110);
        chk("cmp.squash.upd", {3'd0, flag_upd}, 4'd0);

        msr(4'b0001);
        step("msr1");
        alu(4'd13, 1, 32'd0, 0, 1, 0, 0);
        step("movs");
        chk("movs.const", nzcv, 4'b0111);
        alu(4'd13, 1, 32'h8000_0000, 0, 0, 0, 0);
        stall = 1;
        step("movs.stall");
        chk("movs.stall.const", nzcv, 4'b0111);

        msr(4'b0011);
        step("msr3");
        alu(4'd0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
        is_mul = 1;
        step("muls");
        chk("muls.const", nzcv, 4'b1011);

        msr(4'b0101);
        step("msr5");
        msr(4'b1010);
        save = 1;
        step("save");
        idle();
        save = 1; restore = 1;
        step("swap");
        chk("swap.nzcv", nzcv, 4'b0101);
        chk("swap.spsr", spsr_f, 4'b1010);
        idle();
        restore = 1; msr_we = 1; msr_data = 4'b1111;
        step("rst_over_msr");
        chk("rst_over_msr.const", nzcv, 4'b1010);

        for (int i = 0; i < 400; i++) begin
            idle();
            res_valid    = ($urandom_range(0, 9) < 8);
            exec         = ($urandom_range(0, 9) < 8);
            stall        = ($urandom_range(0, 9) < 2);
            alu_op       = 4'($urandom_range(0, 15));
            s_bit        = $urandom_range(0, 1) == 1;
            is_mul       = ($urandom_range(0, 9) < 2);
            alu_result   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            alu_cout     = $urandom_range(0, 1) == 1;
            shifter_cout = $urandom_range(0, 1) == 1;
            op_a_msb     = $urandom_range(0, 1) == 1;
            op_b_msb     = $urandom_range(0, 1) == 1;
            msr_we       = ($urandom_range(0, 9) == 0);
            msr_data     = 4'($urandom_range(0, 15));
            save         = ($urandom_range(0, 9) == 0);
            restore      = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        msr(4'b1111);
        save = 1;
        step("pre_rst");
        alu(4'd4, 1, 32'h8000_0000, 0, 0, 0, 0);
        #3;
        rst = 1;
        #1;
        chk("async.nzcv", nzcv, 4'd0);
        chk("async.spsr", spsr_f, 4'd0);
        chk("async.upd", {3'd0, flag_upd}, 4'd0);
        @(posedge clk);
        #1;
        chk("async.hold", nzcv, 4'd0);
        m_nzcv = 4'd0; m_spsr = 4'd0; m_upd = 1'b0;
        @(negedge clk);
        rst = 0;
        alu(4'd10, 0, 32'd0, 1, 0, 0, 0);
        step("post_rst");
        chk("post_rst.const", nzcv, 4'b0110);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
